// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream arbiter family: width helper and FSM encoding.
package axis_pkg;

    // Ceiling log2, minimum 1, for sizing index and tag fields.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axis_arbiter_rr_select.sv
// Round-robin picker: first requester searching cyclically after the last grant.
module rr_select
    import axis_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IDW   = clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   next,
    output logic             any
);

    int idx;

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        next = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % PORTS;
            if (req[idx]) begin
                next = IDW'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter with source tagging.
module axis_arbiter
    import axis_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int PORTS    = 4,
    localparam int ID_WIDTH = clog2(PORTS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [PORTS*WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]       s_axis_tvalid,
    input  logic [PORTS-1:0]       s_axis_tlast,
    output logic [PORTS-1:0]       s_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [ID_WIDTH-1:0]    m_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] sel_idx;
    logic                sel_any;

    rr_select #(.PORTS(PORTS)) u_rr_select (
        .req  (s_axis_tvalid),
        .last (grant_q),
        .next (sel_idx),
        .any  (sel_any)
    );

    // State and grant registers; grant resets to the top index so port 0 goes first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= ID_WIDTH'(PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next state: lock onto a requester, release only on the tlast handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational pass-through of the granted port while BUSY, zeros otherwise.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tid    = '0;
        if (state_q == BUSY) begin
            m_axis_tdata           = s_axis_tdata[int'(grant_q)*WIDTH +: WIDTH];
            m_axis_tlast           = s_axis_tlast[grant_q];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tid             = grant_q;
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

endmodule

// File: tb/tb_axis_arbiter.sv
// Self-checking bench for axis_arbiter: per-cycle model compare plus directed scenarios.
module tb_axis_arbiter;

    localparam int W = 32;
    localparam int P = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [P*W-1:0] s_axis_tdata = '0;
    logic [P-1:0]  s_axis_tvalid = '0;
    logic [P-1:0]  s_axis_tlast = '0;
    logic [P-1:0]  s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic [1:0]    m_axis_tid;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    axis_arbiter #(.WIDTH(W), .PORTS(P)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the link (or none) and the last owner.
    bit mdl_busy;
    int mdl_owner;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mdl_busy  = 1'b0;
            mdl_owner = P - 1;
        end else if (!mdl_busy) begin
            for (int k = 1; k <= P; k++) begin
                if (s_axis_tvalid[(mdl_owner + k) % P]) begin
                    mdl_owner = (mdl_owner + k) % P;
                    mdl_busy  = 1'b1;
                    break;
                end
            end
        end else if (s_axis_tvalid[mdl_owner] && m_axis_tready && s_axis_tlast[mdl_owner]) begin
            mdl_busy = 1'b0;
        end
    end

    // Compare every output against the model on each falling edge.
    logic [W-1:0] e_data;
    logic [P-1:0] e_rdy;
    logic         e_vld, e_last;
    logic [1:0]   e_id;
    always @(negedge aclk) begin
        e_data = '0; e_rdy = '0; e_vld = 1'b0; e_last = 1'b0; e_id = '0;
        if (aresetn && mdl_busy) begin
            e_data = s_axis_tdata[mdl_owner*W +: W];
            e_vld  = s_axis_tvalid[mdl_owner];
            e_last = s_axis_tlast[mdl_owner];
            e_id   = 2'(mdl_owner);
            e_rdy[mdl_owner] = m_axis_tready;
        end
        chk("cyc_tvalid", 32'(m_axis_tvalid), 32'(e_vld));
        chk("cyc_tdata",  m_axis_tdata, e_data);
        chk("cyc_tlast",  32'(m_axis_tlast), 32'(e_last));
        chk("cyc_tid",    32'(m_axis_tid), 32'(e_id));
        chk("cyc_sready", 32'(s_axis_tready), 32'(e_rdy));
    end

    function automatic logic [31:0] tag(input int p, input int pk, input int bt);
        return {8'(p), 8'(pk), 8'(bt), 8'hA5};
    endfunction

    function automatic int plen(input int p, input int pk, input int flen);
        return (flen > 0) ? flen : 1 + (p + pk) % 3;
    endfunction

    int starts[$];
    int beat_cyc[$];
    int beats;

    // Drive tagged packets from masked ports and score the output stream.
    task automatic run_traffic(input logic [3:0] mask, input int npk, input int flen,
                               input int rmode, input int max_cyc);
        int pk[P]; int bt[P]; int epk[P]; int ebt[P];
        int open; int t; bit done; logic [P-1:0] hs;
        for (int i = 0; i < P; i++) begin pk[i] = 0; bt[i] = 0; epk[i] = 0; ebt[i] = 0; end
        open = -1; beats = 0; starts.delete(); beat_cyc.delete();
        for (int c = 0; c < max_cyc; c++) begin
            done = 1'b1;
            for (int i = 0; i < P; i++) begin
                if (mask[i] && pk[i] < npk) begin
                    done = 1'b0;
                    s_axis_tvalid[i] = 1'b1;
                    s_axis_tdata[i*W +: W] = tag(i, pk[i], bt[i]);
                    s_axis_tlast[i] = (bt[i] == plen(i, pk[i], flen) - 1);
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                end
            end
            if (done) break;
            m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                t = int'(m_axis_tid);
                beats++;
                beat_cyc.push_back(c);
                if (open < 0) starts.push_back(t);
                else chk("e2e_interleave", 32'(t), 32'(open));
                chk("e2e_data", m_axis_tdata, tag(t, epk[t], ebt[t]));
                chk("e2e_last", 32'(m_axis_tlast), 32'(ebt[t] == plen(t, epk[t], flen) - 1));
                if (m_axis_tlast) begin open = -1; epk[t]++; ebt[t] = 0; end
                else begin open = t; ebt[t]++; end
            end
            @(posedge aclk); #1;
            for (int i = 0; i < P; i++) begin
                if (hs[i]) begin
                    if (s_axis_tlast[i]) begin pk[i]++; bt[i] = 0; end
                    else bt[i]++;
                end
            end
        end
        done = 1'b1;
        for (int i = 0; i < P; i++) if (mask[i] && pk[i] < npk) done = 1'b0;
        chk("traffic_done", 32'(done), 32'd1);
        for (int i = 0; i < P; i++) if (mask[i]) chk("traffic_pkts", 32'(epk[i]), 32'(npk));
        s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b1;
    endtask

    task automatic do_reset();
        s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    int cnt;

    initial begin
        // Reset values
        do_reset();
        @(negedge aclk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_sready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk); #1;

        // Port 2, 3-beat packet, data 0x10..0x12
        s_axis_tvalid = 4'b0100; s_axis_tdata[2*W +: W] = 32'h10; s_axis_tlast = '0;
        @(negedge aclk);
        chk("t1_latency_idle", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk); #1;
        for (int b = 0; b < 3; b++) begin
            s_axis_tdata[2*W +: W] = 32'h10 + 32'(b);
            s_axis_tlast[2] = (b == 2);
            @(negedge aclk);
            chk("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("t1_tid",    32'(m_axis_tid), 32'd2);
            chk("t1_tdata",  m_axis_tdata, 32'h10 + 32'(b));
            chk("t1_sready", 32'(s_axis_tready), 32'b0100);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = '0; s_axis_tlast = '0;
        @(negedge aclk);
        chk("t1_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t1_idle_sready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk); #1;

        // All four ports, back-to-back 2-beat packets
        do_reset();
        run_traffic(4'b1111, 2, 2, 0, 200);
        cnt = 0;
        foreach (beat_cyc[i]) if (beat_cyc[i] < 12) cnt++;
        chk("t2_beats_in_12", 32'(cnt), 32'd8);
        chk("t2_order0", 32'(starts[0]), 32'd0);
        chk("t2_order1", 32'(starts[1]), 32'd1);
        chk("t2_order2", 32'(starts[2]), 32'd2);
        chk("t2_order3", 32'(starts[3]), 32'd3);
        chk("t2_order4", 32'(starts[4]), 32'd0);

        // Port 1 stalls mid-packet while port 0 waits
        do_reset();
        s_axis_tvalid = 4'b0010; s_axis_tdata[1*W +: W] = 32'h100;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t3_first_tid", 32'(m_axis_tid), 32'd1);
        @(posedge aclk); #1;
        s_axis_tvalid = 4'b0001; s_axis_tdata[0*W +: W] = 32'h200; s_axis_tlast = 4'b0001;
        repeat (3) begin
            @(negedge aclk);
            chk("t3_hold_tid", 32'(m_axis_tid), 32'd1);
            chk("t3_hold_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("t3_p0_ready", 32'(s_axis_tready[0]), 32'd0);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 4'b0011; s_axis_tdata[1*W +: W] = 32'h101; s_axis_tlast = 4'b0011;
        @(negedge aclk);
        chk("t3_last_data", m_axis_tdata, 32'h101);
        @(posedge aclk); #1;
        s_axis_tvalid = 4'b0001;
        @(negedge aclk);
        chk("t3_bubble", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t3_p0_tid", 32'(m_axis_tid), 32'd0);
        chk("t3_p0_data", m_axis_tdata, 32'h200);
        @(posedge aclk); #1;
        s_axis_tvalid = '0; s_axis_tlast = '0;

        // Backpressure toggling during a 4-beat packet on port 3
        do_reset();
        run_traffic(4'b1000, 1, 4, 1, 100);
        chk("t4_beats", 32'(beats), 32'd4);
        chk("t4_last_cycle", 32'(beat_cyc[3]), 32'd8);

        // Reset mid-packet, then ports 0 and 3 collide
        do_reset();
        s_axis_tvalid = 4'b0100; s_axis_tdata[2*W +: W] = 32'h55; s_axis_tlast = '0;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t5_busy", 32'(m_axis_tvalid), 32'd1);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t5_rst_tdata",  m_axis_tdata, 32'd0);
        chk("t5_rst_tid",    32'(m_axis_tid), 32'd0);
        chk("t5_rst_sready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        s_axis_tvalid = 4'b1001; s_axis_tdata[0*W +: W] = 32'hA0; s_axis_tdata[3*W +: W] = 32'hA3;
        s_axis_tlast = 4'b1001;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t5_winner", 32'(m_axis_tid), 32'd0);
        chk("t5_winner_data", m_axis_tdata, 32'hA0);
        @(posedge aclk); #1;
        s_axis_tvalid = '0; s_axis_tlast = '0;

        // End to end: three sources, ten variable-length packets each, random backpressure
        do_reset();
        run_traffic(4'b0111, 10, 0, 2, 2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
